// File: rtl/aurora_block_sync_ctrl.sv
// Aurora 64b/66b receive-lane block synchroniser.
// Hunts for header alignment via gearbox/SERDES slips, monitors errors once locked.
module aurora_block_sync_ctrl #(
   parameter int LOCK_CNT   = 64,
   parameter int ERR_WIN    = 64,
   parameter int ERR_MAX    = 16,
   parameter int SLIP_WAIT  = 16,
   parameter int GBOX_SLIPS = 66
) (
   input  logic       clk_rx_i,
   input  logic       rst_i,
   input  logic [1:0] header_i,
   input  logic       header_valid_i,
   output logic       gearbox_slip_o,
   output logic       serdes_slip_o,
   output logic       locked_o,
   output logic [7:0] lock_loss_cnt_o,
   output logic [1:0] state_o
);

   localparam int GW  = $clog2(LOCK_CNT + 1);
   localparam int WW  = $clog2(ERR_WIN + 1);
   localparam int BW  = $clog2(ERR_MAX + 1);
   localparam int TW  = $clog2(SLIP_WAIT + 1);
   localparam int SW  = $clog2(GBOX_SLIPS + 1);

   localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);
   localparam logic [WW-1:0] WIN_LAST  = WW'(ERR_WIN - 1);
   localparam logic [BW-1:0] BAD_LAST  = BW'(ERR_MAX - 1);
   localparam logic [TW-1:0] WAIT_LAST = TW'(SLIP_WAIT - 1);
   localparam logic [SW-1:0] GBOX_MAX  = SW'(GBOX_SLIPS);

   typedef enum logic [1:0] {
      S_HUNT   = 2'd0,
      S_WAIT   = 2'd1,
      S_LOCKED = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [GW-1:0] good_q, good_d;
   logic [WW-1:0] win_q, win_d;
   logic [BW-1:0] bad_q, bad_d;
   logic [TW-1:0] wait_q, wait_d;
   logic [SW-1:0] gbox_q, gbox_d;
   logic [7:0]    loss_q, loss_d;
   logic          gslip_q, gslip_d;
   logic          sslip_q, sslip_d;
   logic          locked_q;
   logic          hdr_ok;

   assign hdr_ok = header_i[1] ^ header_i[0];

   // State, counters and all outputs are registered here.
   always_ff @(posedge clk_rx_i) begin
      if (rst_i) begin
         state_q  <= S_HUNT;
         good_q   <= '0;
         win_q    <= '0;
         bad_q    <= '0;
         wait_q   <= '0;
         gbox_q   <= '0;
         loss_q   <= '0;
         gslip_q  <= 1'b0;
         sslip_q  <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         good_q   <= good_d;
         win_q    <= win_d;
         bad_q    <= bad_d;
         wait_q   <= wait_d;
         gbox_q   <= gbox_d;
         loss_q   <= loss_d;
         gslip_q  <= gslip_d;
         sslip_q  <= sslip_d;
         locked_q <= (state_d == S_LOCKED);
      end
   end

   // Next-state and counter update logic; slips are decided on entry to WAIT.
   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      win_d   = win_q;
      bad_d   = bad_q;
      wait_d  = wait_q;
      gbox_d  = gbox_q;
      loss_d  = loss_q;
      gslip_d = 1'b0;
      sslip_d = 1'b0;
      unique case (state_q)
         S_HUNT: begin
            if (header_valid_i) begin
               if (hdr_ok) begin
                  if (good_q == GOOD_LAST) begin
                     state_d = S_LOCKED;
                     good_d  = '0;
                     win_d   = '0;
                     bad_d   = '0;
                     gbox_d  = '0;
                  end else begin
                     good_d = good_q + GW'(1);
                  end
               end else begin
                  state_d = S_WAIT;
                  good_d  = '0;
                  wait_d  = '0;
                  if (gbox_q < GBOX_MAX) begin
                     gslip_d = 1'b1;
                     gbox_d  = gbox_q + SW'(1);
                  end else begin
                     sslip_d = 1'b1;
                     gbox_d  = '0;
                  end
               end
            end
         end
         S_WAIT: begin
            if (wait_q == WAIT_LAST) begin
               state_d = S_HUNT;
               wait_d  = '0;
            end else begin
               wait_d = wait_q + TW'(1);
            end
         end
         S_LOCKED: begin
            if (header_valid_i) begin
               if (!hdr_ok && bad_q == BAD_LAST) begin
                  state_d = S_HUNT;
                  good_d  = '0;
                  win_d   = '0;
                  bad_d   = '0;
                  if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
               end else if (win_q == WIN_LAST) begin
                  win_d = '0;
                  bad_d = '0;
               end else begin
                  win_d = win_q + WW'(1);
                  if (!hdr_ok) bad_d = bad_q + BW'(1);
               end
            end
         end
         default: state_d = S_HUNT;
      endcase
   end

   assign gearbox_slip_o  = gslip_q;
   assign serdes_slip_o   = sslip_q;
   assign locked_o        = locked_q;
   assign lock_loss_cnt_o = loss_q;
   assign state_o         = state_q;

endmodule
